// File: rtl/hid_arbiter.sv
`timescale 1ns/1ps
// Two-requester packet arbiter feeding a HID byte decoder, with forced idle gaps between strobes.
// Optional stall timeout is compiled in with HID_ARBITER_TIMEOUT_EN.
module hid_arbiter #(
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_start,
  input  logic       req0_last,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic       req1_start,
  input  logic       req1_last,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       hid_strobe,
  output logic       hid_start,
  output logic [7:0] hid_data,
  output logic       owner,
  output logic       busy,
  output logic       abort,
  output logic [7:0] drop_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned GW = 4;

  if (GAP > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("hid_arbiter: GAP or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  state_t          state, state_n;
  logic            owner_q, owner_n;
  logic            last_q, last_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic            acc, drop0, drop1;
  logic            elig0, elig1, grant0, grant1;
  logic            sel;
  logic            sel_valid, sel_start, sel_last;
  logic [DW-1:0]   sel_data;
  logic [DW:0]     drop_sum;

  // In IDLE the source is the arbitration winner, otherwise the current owner.
  assign elig0     = req0_valid && req0_start;
  assign elig1     = req1_valid && req1_start;
  assign grant0    = elig0 && (!elig1 || last_q);
  assign grant1    = elig1 && !grant0;
  assign sel       = (state == S_IDLE) ? grant1 : owner_q;
  assign sel_valid = sel ? req1_valid : req0_valid;
  assign sel_start = sel ? req1_start : req0_start;
  assign sel_last  = sel ? req1_last  : req0_last;
  assign sel_data  = sel ? req1_data  : req0_data;
  assign drop_sum  = {1'b0, drop_cnt} + (DW+1)'(drop0) + (DW+1)'(drop1);
  assign owner     = owner_q;

`ifdef HID_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LIM = (TIMEOUT > 1) ? CW'(TIMEOUT - 1) : CW'(1);
  logic [CW-1:0] to_cnt, to_cnt_n;
  logic          abort_n;
`endif

  always_comb begin
    state_n    = state;
    owner_n    = owner_q;
    last_n     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    acc        = 1'b0;
    drop0      = 1'b0;
    drop1      = 1'b0;
    gap_cnt_n  = (gap_cnt != '0) ? gap_cnt - GW'(1) : '0;
`ifdef HID_ARBITER_TIMEOUT_EN
    to_cnt_n   = '0;
    abort_n    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!reset && gap_cnt == '0) begin
          req0_ready = !elig0 || grant0;
          req1_ready = !elig1 || grant1;
          drop0      = req0_valid && !req0_start;
          drop1      = req1_valid && !req1_start;
          if (grant0 || grant1) begin
            acc     = 1'b1;
            owner_n = grant1;
          end
        end
      end
      S_ACTIVE: begin
        if (!reset && gap_cnt == '0) begin
          req0_ready = !owner_q;
          req1_ready = owner_q;
          acc        = sel_valid;
        end
      end
      S_GAP: begin
        // Leave one cycle early so IDLE acceptance lands exactly GAP cycles after the last byte.
        if (gap_cnt <= GW'(1)) begin
          state_n = S_IDLE;
          last_n  = owner_q;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (acc) begin
      gap_cnt_n = GW'(GAP);
      if (sel_last) begin
        if (GAP == 0) begin
          state_n = S_IDLE;
          last_n  = owner_n;
        end else begin
          state_n = S_GAP;
        end
      end else begin
        state_n = S_ACTIVE;
      end
    end

`ifdef HID_ARBITER_TIMEOUT_EN
    // Count owner stall cycles; the pulse lands TIMEOUT cycles after the last acceptance.
    if (state == S_ACTIVE && !acc && !sel_valid) begin
      to_cnt_n = to_cnt + CW'(1);
      if (to_cnt_n >= TO_LIM) begin
        abort_n  = 1'b1;
        state_n  = S_IDLE;
        to_cnt_n = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      gap_cnt    <= '0;
      hid_strobe <= 1'b0;
      hid_start  <= 1'b0;
      hid_data   <= '0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      owner_q    <= owner_n;
      last_q     <= last_n;
      gap_cnt    <= gap_cnt_n;
      hid_strobe <= acc;
      hid_start  <= acc && sel_start;
      if (acc) hid_data <= sel_data;
      busy       <= (state_n != S_IDLE);
      drop_cnt   <= (drop_sum > (DW+1)'(255)) ? DW'(255) : drop_sum[DW-1:0];
    end
  end

`ifdef HID_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      abort  <= 1'b0;
    end else begin
      to_cnt <= to_cnt_n;
      abort  <= abort_n;
    end
  end
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_hid_arbiter.sv
`timescale 1ns/1ps
// Directed bench for hid_arbiter (GAP=2, TIMEOUT=10) with per-cycle traffic runner and logs.
module tb_hid_arbiter;

  localparam int LOGN = 512;

  typedef struct packed {
    logic       start;
    logic       last;
    logic [7:0] data;
  } byte_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_start = 1'b0, req0_last = 1'b0;
  logic       req1_valid = 1'b0, req1_start = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, hid_strobe, hid_start, owner, busy, abort;
  logic [7:0] hid_data, drop_cnt;

  int n_pass = 0;
  int n_total = 0;

  byte_t      q0[$], q1[$];
  int         from0 = 0, from1 = 0;
  int         obs_cyc[$];
  logic [7:0] obs_dat[$];
  logic       obs_st[$], obs_own[$];
  logic       r0_log[LOGN], r1_log[LOGN], busy_log[LOGN], abort_log[LOGN];
  logic [7:0] drop_log[LOGN];

  hid_arbiter #(.GAP(2), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_start(req0_start), .req0_last(req0_last), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_start(req1_start), .req1_last(req1_last), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .hid_strobe(hid_strobe), .hid_start(hid_start), .hid_data(hid_data),
    .owner(owner), .busy(busy), .abort(abort), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    {req0_valid, req0_start, req0_last, req0_data} = '0;
    {req1_valid, req1_start, req1_last, req1_data} = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    q0.delete(); q1.delete();
    from0 = 0; from1 = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents queue heads each cycle, logs DUT outputs at the falling edge, pops on handshake.
  task automatic run_traffic(input int ncyc);
    obs_cyc.delete(); obs_dat.delete(); obs_st.delete(); obs_own.delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(posedge clk); #1;
      if (q0.size() > 0 && cyc >= from0) {req0_valid, req0_start, req0_last, req0_data} = {1'b1, q0[0]};
      else {req0_valid, req0_start, req0_last, req0_data} = '0;
      if (q1.size() > 0 && cyc >= from1) {req1_valid, req1_start, req1_last, req1_data} = {1'b1, q1[0]};
      else {req1_valid, req1_start, req1_last, req1_data} = '0;
      @(negedge clk);
      if (cyc < LOGN) begin
        r0_log[cyc] = req0_ready; r1_log[cyc] = req1_ready;
        busy_log[cyc] = busy; abort_log[cyc] = abort; drop_log[cyc] = drop_cnt;
      end
      if (hid_strobe) begin
        obs_cyc.push_back(cyc); obs_dat.push_back(hid_data);
        obs_st.push_back(hid_start); obs_own.push_back(owner);
      end
      if (req0_valid && req0_ready) void'(q0.pop_front());
      if (req1_valid && req1_ready) void'(q1.pop_front());
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_start = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    else n_pass++;
    n_total++;
    if ({hid_strobe, hid_start, hid_data, owner, busy, abort, drop_cnt} !== 21'd0)
      $display("FAIL reset_outputs: got strobe=%b start=%b data=%h owner=%b busy=%b abort=%b drop=%0d want all 0",
               hid_strobe, hid_start, hid_data, owner, busy, abort, drop_cnt);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_packet();
    int         ec[3] = '{1, 4, 7};
    logic [7:0] ed[3] = '{8'h01, 8'h23, 8'h81};
    logic       es[3] = '{1'b1, 1'b0, 1'b0};
    apply_reset();
    q0.push_back({1'b1, 1'b0, 8'h01});
    q0.push_back({1'b0, 1'b0, 8'h23});
    q0.push_back({1'b0, 1'b1, 8'h81});
    run_traffic(12);
    n_total++;
    if (obs_cyc.size() !== 3) $display("FAIL packet_count: got %0d strobes want 3", obs_cyc.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (i >= obs_cyc.size()) $display("FAIL packet_strobe%0d: missing want cyc=%0d data=%h", i, ec[i], ed[i]);
      else if (obs_cyc[i] !== ec[i] || obs_dat[i] !== ed[i] || obs_st[i] !== es[i] || obs_own[i] !== 1'b0)
        $display("FAIL packet_strobe%0d: got cyc=%0d data=%h start=%b owner=%b want cyc=%0d data=%h start=%b owner=0",
                 i, obs_cyc[i], obs_dat[i], obs_st[i], obs_own[i], ec[i], ed[i], es[i]);
      else n_pass++;
    end
    n_total++;
    if ({busy_log[8], busy_log[9]} !== 2'b10)
      $display("FAIL packet_busy_fall: got busy[8:9]=%b%b want 10", busy_log[8], busy_log[9]);
    else n_pass++;
  endtask

  task automatic test_tie();
    int         ec[4] = '{1, 4, 7, 10};
    logic [7:0] ed[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic       es[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       eo[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    q0.push_back({1'b1, 1'b0, 8'hAA});
    q0.push_back({1'b0, 1'b1, 8'hBB});
    q0.push_back({1'b1, 1'b1, 8'hDD});
    q1.push_back({1'b1, 1'b1, 8'hCC});
    run_traffic(14);
    n_total++;
    if ({r0_log[0], r1_log[0]} !== 2'b10) $display("FAIL tie_first_ready: got %b%b want 10", r0_log[0], r1_log[0]);
    else n_pass++;
    n_total++;
    if ({r0_log[6], r1_log[6]} !== 2'b01) $display("FAIL tie_second_ready: got %b%b want 01", r0_log[6], r1_log[6]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= obs_cyc.size()) $display("FAIL tie_strobe%0d: missing want data=%h", i, ed[i]);
      else if (obs_cyc[i] !== ec[i] || obs_dat[i] !== ed[i] || obs_st[i] !== es[i] || obs_own[i] !== eo[i])
        $display("FAIL tie_strobe%0d: got cyc=%0d data=%h start=%b owner=%b want cyc=%0d data=%h start=%b owner=%b",
                 i, obs_cyc[i], obs_dat[i], obs_st[i], obs_own[i], ec[i], ed[i], es[i], eo[i]);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    int         ec[4] = '{1, 4, 7, 10};
    logic [7:0] ed[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       eo[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int         ones = 0;
    int         aborts = 0;
    apply_reset();
    q1.push_back({1'b1, 1'b0, 8'h11});
    q1.push_back({1'b0, 1'b0, 8'h22});
    q1.push_back({1'b0, 1'b1, 8'h33});
    q0.push_back({1'b1, 1'b1, 8'h44});
    from0 = 1;
    run_traffic(14);
    for (int c = 1; c <= 8; c++) ones += int'(r0_log[c]);
    for (int c = 0; c < 14; c++) aborts += int'(abort_log[c]);
    n_total++;
    if (ones !== 0 || r0_log[9] !== 1'b1)
      $display("FAIL hold_ready0: got %0d ready cycles in 1..8, ready[9]=%b want 0 and 1", ones, r0_log[9]);
    else n_pass++;
    n_total++;
    if (drop_cnt !== 8'd0 || aborts !== 0) $display("FAIL hold_no_drop: got drop=%0d aborts=%0d want 0 0", drop_cnt, aborts);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= obs_cyc.size()) $display("FAIL hold_strobe%0d: missing want data=%h", i, ed[i]);
      else if (obs_cyc[i] !== ec[i] || obs_dat[i] !== ed[i] || obs_own[i] !== eo[i])
        $display("FAIL hold_strobe%0d: got cyc=%0d data=%h owner=%b want cyc=%0d data=%h owner=%b",
                 i, obs_cyc[i], obs_dat[i], obs_own[i], ec[i], ed[i], eo[i]);
      else n_pass++;
    end
  endtask

  task automatic test_orphans();
    int busy_ones = 0;
    apply_reset();
    for (int i = 0; i < 128; i++) begin
      q0.push_back({1'b0, 1'b0, 8'(i)});
      q1.push_back({1'b0, 1'b0, 8'(i + 1)});
    end
    run_traffic(130);
    for (int c = 0; c < 130; c++) busy_ones += int'(busy_log[c]);
    n_total++;
    if (drop_log[3] !== 8'd6 || drop_log[127] !== 8'd254)
      $display("FAIL orphan_dual_inc: got drop[3]=%0d drop[127]=%0d want 6 254", drop_log[3], drop_log[127]);
    else n_pass++;
    n_total++;
    if (drop_log[128] !== 8'd255 || drop_cnt !== 8'd255 || busy_ones !== 0)
      $display("FAIL orphan_dual_sat: got drop[128]=%0d final=%0d busy=%0d want 255 255 0", drop_log[128], drop_cnt, busy_ones);
    else n_pass++;
    apply_reset();
    for (int i = 0; i < 300; i++) q0.push_back({1'b0, 1'b0, 8'(i)});
    run_traffic(305);
    n_total++;
    if (drop_log[100] !== 8'd100 || drop_log[255] !== 8'd255 || drop_cnt !== 8'd255)
      $display("FAIL orphan_sat: got drop[100]=%0d drop[255]=%0d final=%0d want 100 255 255", drop_log[100], drop_log[255], drop_cnt);
    else n_pass++;
    n_total++;
    if (obs_cyc.size() !== 0) $display("FAIL orphan_no_strobe: got %0d strobes want 0", obs_cyc.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] pre;
    apply_reset();
    q1.push_back({1'b1, 1'b0, 8'h55});
    q1.push_back({1'b0, 1'b0, 8'h66});
    q1.push_back({1'b0, 1'b1, 8'h77});
    run_traffic(1);
    pre = {hid_strobe, busy, owner, hid_start};
    #1 reset = 1'b1;
    req1_valid = 1'b1; req1_start = 1'b1;
    #1;
    n_total++;
    if (pre !== 4'b1111 || {hid_strobe, busy, owner, hid_start, hid_data, req1_ready} !== 13'd0)
      $display("FAIL reset_mid_outputs: got pre=%b strobe=%b busy=%b owner=%b start=%b data=%h ready1=%b want 1111 then all 0",
               pre, hid_strobe, busy, owner, hid_start, hid_data, req1_ready);
    else n_pass++;
    clear_inputs();
    q0.delete(); q1.delete();
    @(posedge clk); #1 reset = 1'b0;
    q0.push_back({1'b1, 1'b1, 8'hA0});
    q1.push_back({1'b1, 1'b1, 8'hB0});
    run_traffic(7);
    n_total++;
    if (obs_cyc.size() !== 2) $display("FAIL reset_mid_count: got %0d strobes want 2", obs_cyc.size());
    else n_pass++;
    n_total++;
    if (obs_cyc.size() < 1) $display("FAIL reset_mid_tie: missing strobe want data=a0 owner=0");
    else if (obs_cyc[0] !== 1 || obs_dat[0] !== 8'hA0 || obs_own[0] !== 1'b0)
      $display("FAIL reset_mid_tie: got cyc=%0d data=%h owner=%b want cyc=1 data=a0 owner=0", obs_cyc[0], obs_dat[0], obs_own[0]);
    else n_pass++;
  endtask

`ifdef HID_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    q0.push_back({1'b1, 1'b0, 8'hE1});
    run_traffic(14);
    n_total++;
    if ({abort_log[9], abort_log[10], abort_log[11]} !== 3'b010)
      $display("FAIL timeout_abort: got abort[9:11]=%b%b%b want 010", abort_log[9], abort_log[10], abort_log[11]);
    else n_pass++;
    n_total++;
    if ({busy_log[9], busy_log[10]} !== 2'b10 || obs_cyc.size() !== 1)
      $display("FAIL timeout_idle: got busy[9:10]=%b%b strobes=%0d want 10 1", busy_log[9], busy_log[10], obs_cyc.size());
    else n_pass++;
    q0.push_back({1'b1, 1'b1, 8'hE2});
    q1.push_back({1'b1, 1'b1, 8'hF2});
    run_traffic(6);
    n_total++;
    if (obs_cyc.size() < 1) $display("FAIL timeout_rearb: missing strobe want data=e2");
    else if (obs_dat[0] !== 8'hE2 || obs_own[0] !== 1'b0)
      $display("FAIL timeout_rearb: got data=%h owner=%b want e2 0", obs_dat[0], obs_own[0]);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_packet();
    test_tie();
    test_hold();
    test_orphans();
    test_reset_mid();
`ifdef HID_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
